div_unit: RTL and testbench
===========================

# div_unit

Multi-cycle 32-bit integer divider for the execute stage of the five-stage MIPS pipeline. It implements DIV/DIVU with a radix-2 restoring algorithm, one quotient bit per cycle. It drives `stall_divE` into the hazard unit and honours `flush_exceptM`. Results go to the HI/LO write path as `hiE`/`loE`.

## Interface
Parameters:
- none; data width is fixed at 32.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `div_startE` input 1: a DIV/DIVU instruction occupies E.
- `div_signedE` input 1: 1 = DIV (signed), 0 = DIVU.
- `srcAE` input 32: dividend (rs).
- `srcBE` input 32: divisor (rt).
- `ext_stallE` input 1: E is held by a non-divider source (`stall_from_if | stall_from_mem`). It must not include `stall_divE`.
- `flush_exceptM` input 1: exception flush; cancels any operation.
- `stall_divE` output 1: holds the pipeline while a division is in progress.
- `div_readyE` output 1: `hiE`/`loE` are valid this cycle.
- `hiE` output 32: remainder.
- `loE` output 32: quotient.

## Operation
States:
- **IDLE**
  - If `div_startE & ~flush_exceptM`, latch the operands.
  - If the divisor is 0, go to DONE.
  - Otherwise load the magnitudes, clear the 6-bit counter, and go to DIV.
- **DIV**
  - Each cycle, shift {rem,quo} left 1.
  - Trial-subtract the divisor magnitude (33-bit subtract).
  - On non-negative, keep the difference and set the quotient LSB to 1.
  - Increment the counter. After the 32nd iteration (counter == 31), go to DONE.
- **DONE**
  - `div_readyE` = 1 and the result registers are stable.
  - If `ext_stallE`, stay in DONE and hold the result.
  - Otherwise return to IDLE.
  - `div_startE` seen in DONE never restarts the operation.

Signed handling:
- The divider operates on unsigned magnitudes.
- Quotient sign = srcA[31] ^ srcB[31]; remainder sign = srcA[31]. Negation is applied on entry to DONE.
- -2^31 / -1 → `loE` = 0x80000000, `hiE` = 0 (wraps; no trap).

Divide by zero (both modes):
- `loE` = 0xFFFFFFFF, `hiE` = srcA, with no sign correction.

Stall output:
- `stall_divE` = (IDLE & `div_startE` & ~`flush_exceptM`) | DIV. It is combinational and low in DONE.

Cancel:
- `flush_exceptM` in any state → IDLE on the next edge; the result is discarded and `div_readyE` drops.
- When flush and start are both high in IDLE, flush wins.

Reset:
- State = IDLE, counter = 0, `hiE` = `loE` = 0, `div_readyE` = 0, `stall_divE` = 0.
- Asserting `rst` mid-division aborts immediately with no residual stall.

## Timing
- Start accepted at cycle T (IDLE).
- `stall_divE` is high for cycles T..T+32 (33 cycles).
- DONE at T+33: `div_readyE` = 1 and `stall_divE` = 0, so E advances and HI/LO are captured at the end of T+33.
- Divide by zero: `stall_divE` is high only at T; DONE at T+1.
- Back-to-back divides:
  - The second DIV enters E the cycle after DONE exits, so it starts no earlier than T+34.
  - IDLE samples it that cycle.
- `ext_stallE` during DIV has no effect on the iteration; it only extends DONE.
- `hiE`/`loE` change only on entry to DONE or on reset.

## Test plan
- DIVU 100/7, no external stall:
  - `stall_divE` high exactly 33 cycles.
  - Then `div_readyE` for 1 cycle with `loE` = 14, `hiE` = 2.
  - State returns to IDLE.
- DIV -7/2 → `loE` = 0xFFFFFFFD, `hiE` = 0xFFFFFFFF.
- DIV 7/-2 → `loE` = 0xFFFFFFFD, `hiE` = 1.
- DIV 0x80000000/0xFFFFFFFF → `loE` = 0x80000000, `hiE` = 0.
- DIVU 0xFFFFFFFF/1 → `loE` = 0xFFFFFFFF, `hiE` = 0.
- Divide by zero:
  - DIVU 0x1234/0 → `stall_divE` 1 cycle.
  - Then `loE` = 0xFFFFFFFF, `hiE` = 0x1234.
- `flush_exceptM` pulse at iteration 10:
  - `stall_divE` low the next cycle and state is IDLE.
  - A fresh DIVU 9/3 afterwards gives `loE` = 3, `hiE` = 0 after 33 stall cycles.
- `ext_stallE` held high 5 cycles spanning DONE entry, with `div_startE` held high:
  - `div_readyE` stays 1 with a stable result, and no restart occurs.
  - After release, IDLE.
- `rst` asserted mid-DIV with clk stopped: outputs go to 0 and `stall_divE` = 0 immediately.

Source files
------------

// File: rtl/div_unit.sv
// Radix-2 restoring 32-bit DIV/DIVU for the execute stage, one quotient bit per cycle.
// 33 stall cycles per divide (1 for divide-by-zero); the result is held in DONE while ext_stallE is high.
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        div_startE,
  input  logic        div_signedE,
  input  logic [31:0] srcAE,
  input  logic [31:0] srcBE,
  input  logic        ext_stallE,
  input  logic        flush_exceptM,
  output logic        stall_divE,
  output logic        div_readyE,
  output logic [31:0] hiE,
  output logic [31:0] loE
);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

  state_t      r_state;
  logic [5:0]  r_cnt;
  logic [31:0] r_rem;
  logic [31:0] r_quo;
  logic [31:0] r_dvsr;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_ready;

  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [32:0] w_shift;
  logic [32:0] w_diff;
  logic [31:0] w_rem_nxt;
  logic [31:0] w_quo_nxt;
  logic [31:0] w_hi_fin;
  logic [31:0] w_lo_fin;

  assign w_a_neg = div_signedE & srcAE[31];
  assign w_b_neg = div_signedE & srcBE[31];
  assign w_a_mag = w_a_neg ? (32'd0 - srcAE) : srcAE;
  assign w_b_mag = w_b_neg ? (32'd0 - srcBE) : srcBE;

  // Shift the next dividend bit into the partial remainder and trial-subtract.
  assign w_shift   = {r_rem, r_quo[31]};
  assign w_diff    = w_shift - {1'b0, r_dvsr};
  assign w_rem_nxt = w_diff[32] ? w_shift[31:0] : w_diff[31:0];
  assign w_quo_nxt = {r_quo[30:0], ~w_diff[32]};

  assign w_hi_fin = r_neg_r ? (32'd0 - w_rem_nxt) : w_rem_nxt;
  assign w_lo_fin = r_neg_q ? (32'd0 - w_quo_nxt) : w_quo_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 6'd0;
      r_rem   <= 32'd0;
      r_quo   <= 32'd0;
      r_dvsr  <= 32'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_ready <= 1'b0;
    end else if (flush_exceptM) begin
      r_state <= S_IDLE;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (div_startE) begin
            if (srcBE == 32'd0) begin
              r_hi    <= srcAE;
              r_lo    <= 32'hFFFF_FFFF;
              r_ready <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_rem   <= 32'd0;
              r_quo   <= w_a_mag;
              r_dvsr  <= w_b_mag;
              r_neg_q <= w_a_neg ^ w_b_neg;
              r_neg_r <= w_a_neg;
              r_cnt   <= 6'd0;
              r_state <= S_DIV;
            end
          end
        end
        S_DIV: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == 6'd31) begin
            r_hi    <= w_hi_fin;
            r_lo    <= w_lo_fin;
            r_ready <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          // A start still asserted here belongs to the finishing instruction.
          if (!ext_stallE) begin
            r_ready <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_ready <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign stall_divE = ((r_state == S_IDLE) & div_startE & ~flush_exceptM) | (r_state == S_DIV);
  assign div_readyE = r_ready;
  assign hiE        = r_hi;
  assign loE        = r_lo;

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: table-driven divides through a result scoreboard, plus flush, ext-stall and reset sequences.
module tb_div_unit;

  logic        clk;
  logic        clk_en;
  logic        rst;
  logic        div_startE;
  logic        div_signedE;
  logic [31:0] srcAE;
  logic [31:0] srcBE;
  logic        ext_stallE;
  logic        flush_exceptM;
  logic        stall_divE;
  logic        div_readyE;
  logic [31:0] hiE;
  logic [31:0] loE;

  typedef struct packed {
    logic [31:0] lo;
    logic [31:0] hi;
  } res_t;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    int          stalls;
  } vec_t;

  res_t sb[$];
  int   checks;
  int   errors;

  div_unit dut (
    .clk          (clk),
    .rst          (rst),
    .div_startE   (div_startE),
    .div_signedE  (div_signedE),
    .srcAE        (srcAE),
    .srcBE        (srcBE),
    .ext_stallE   (ext_stallE),
    .flush_exceptM(flush_exceptM),
    .stall_divE   (stall_divE),
    .div_readyE   (div_readyE),
    .hiE          (hiE),
    .loE          (loE)
  );

  initial clk = 1'b0;
  always #5 clk = clk_en ? ~clk : clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: truncating division, remainder takes the dividend sign.
  function automatic res_t model(input logic s, input logic [31:0] a, input logic [31:0] b);
    res_t        r;
    logic [31:0] q;
    logic [31:0] m;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      m = a;
    end else if (!s) begin
      q = a / b;
      m = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      m = 32'd0;
    end else begin
      q = $signed(a) / $signed(b);
      m = $signed(a) % $signed(b);
    end
    r.lo = q;
    r.hi = m;
    return r;
  endfunction

  task automatic run(input logic s, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] elo, input logic [31:0] ehi, input int estall,
                     input string name);
    res_t exp;
    int   n;
    sb.push_back({elo, ehi});
    @(negedge clk);
    div_startE  = 1'b1;
    div_signedE = s;
    srcAE       = a;
    srcBE       = b;
    n = 0;
    #1;
    while (stall_divE && n < 200) begin
      n++;
      @(negedge clk);
      #1;
    end
    chk({name, " stall_cycles"}, n, estall);
    chk({name, " ready"}, {31'd0, div_readyE}, 32'd1);
    exp = sb.pop_front();
    chk({name, " lo"}, loE, exp.lo);
    chk({name, " hi"}, hiE, exp.hi);
    @(negedge clk);
    div_startE = 1'b0;
    #1;
    chk({name, " ready_drop"}, {31'd0, div_readyE}, 32'd0);
    chk({name, " idle_stall"}, {31'd0, stall_divE}, 32'd0);
  endtask

  initial begin
    vec_t        tbl[10];
    res_t        r;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;
    checks        = 0;
    errors        = 0;
    clk_en        = 1'b1;
    rst           = 1'b1;
    div_startE    = 1'b0;
    div_signedE   = 1'b0;
    srcAE         = 32'd0;
    srcBE         = 32'd0;
    ext_stallE    = 1'b0;
    flush_exceptM = 1'b0;

    tbl[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          33};
    tbl[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  33};
    tbl[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          33};
    tbl[3] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          33};
    tbl[4] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          33};
    tbl[5] = '{1'b0, 32'h1234,       32'd0,          32'hFFFF_FFFF,  32'h1234,       1};
    tbl[6] = '{1'b1, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF9,  1};
    tbl[7] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  33};
    tbl[8] = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  33};
    tbl[9] = '{1'b0, 32'd5,          32'd9,          32'd0,          32'd5,          33};

    #1;
    chk("reset stall", {31'd0, stall_divE}, 32'd0);
    chk("reset ready", {31'd0, div_readyE}, 32'd0);
    chk("reset lo", loE, 32'd0);
    chk("reset hi", hiE, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++)
      run(tbl[i].sgn, tbl[i].a, tbl[i].b, tbl[i].lo, tbl[i].hi, tbl[i].stalls, $sformatf("vec%0d", i));

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = (i == 0) ? 32'd3 : ($urandom >> $urandom_range(0, 28));
      rs = i[0];
      r  = model(rs, ra, rb);
      run(rs, ra, rb, r.lo, r.hi, (rb == 32'd0) ? 1 : 33, $sformatf("rnd%0d", i));
    end

    // Flush at iteration 10, then a fresh divide.
    @(negedge clk);
    div_startE = 1'b1; div_signedE = 1'b0; srcAE = 32'd100; srcBE = 32'd7;
    repeat (11) @(negedge clk);
    flush_exceptM = 1'b1;
    #1;
    chk("flush in_div_stall", {31'd0, stall_divE}, 32'd1);
    @(negedge clk);
    flush_exceptM = 1'b0;
    div_startE    = 1'b0;
    #1;
    chk("flush stall_after", {31'd0, stall_divE}, 32'd0);
    chk("flush ready_after", {31'd0, div_readyE}, 32'd0);

    // Flush beats start in IDLE.
    @(negedge clk);
    div_startE = 1'b1; flush_exceptM = 1'b1;
    #1;
    chk("flush_vs_start stall", {31'd0, stall_divE}, 32'd0);
    @(negedge clk);
    div_startE = 1'b0; flush_exceptM = 1'b0;
    #1;
    chk("flush_vs_start idle", {31'd0, stall_divE}, 32'd0);
    chk("flush_vs_start ready", {31'd0, div_readyE}, 32'd0);
    run(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33, "post_flush");

    // ext_stallE high for 5 cycles spanning DONE entry, start held throughout.
    sb.push_back({32'd14, 32'd2});
    @(negedge clk);
    div_startE = 1'b1; div_signedE = 1'b0; srcAE = 32'd100; srcBE = 32'd7;
    r = sb.pop_front();
    for (int c = 1; c <= 36; c++) begin
      @(negedge clk);
      ext_stallE = (c >= 31 && c <= 35);
      #1;
      if (c == 32)
        chk("ext_stall div_runs", {31'd0, stall_divE}, 32'd1);
      if (c >= 33) begin
        chk($sformatf("ext_stall ready c%0d", c), {31'd0, div_readyE}, 32'd1);
        chk($sformatf("ext_stall nostall c%0d", c), {31'd0, stall_divE}, 32'd0);
        chk($sformatf("ext_stall lo c%0d", c), loE, r.lo);
        chk($sformatf("ext_stall hi c%0d", c), hiE, r.hi);
      end
    end
    @(negedge clk);
    div_startE = 1'b0;
    #1;
    chk("ext_stall ready_drop", {31'd0, div_readyE}, 32'd0);
    chk("ext_stall idle", {31'd0, stall_divE}, 32'd0);

    // Reset mid-division with the clock stopped.
    @(negedge clk);
    div_startE = 1'b1; div_signedE = 1'b0; srcAE = 32'd100; srcBE = 32'd7;
    repeat (5) @(negedge clk);
    clk_en = 1'b0;
    div_startE = 1'b0;
    #1;
    chk("pre_rst stall", {31'd0, stall_divE}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst stall", {31'd0, stall_divE}, 32'd0);
    chk("rst ready", {31'd0, div_readyE}, 32'd0);
    chk("rst lo", loE, 32'd0);
    chk("rst hi", hiE, 32'd0);
    #5;
    rst    = 1'b0;
    clk_en = 1'b1;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
